// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states, owner encoding,
// latency counter sizing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   // One spare bit so MEM_LAT-1 always fits, including MEM_LAT=1.
   function automatic int cnt_width(input int lat);
      return $clog2(lat) + 1;
   endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times one memory access; reloads to MEM_LAT-1 on grant and
// flags the final access cycle.
module arb_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = cnt_width(MEM_LAT)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(MEM_LAT - 1);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU / loader) for a single unified memory with fixed access latency.
// Define ARB_ROUND_ROBIN_EN to replace fixed CPU priority with round-robin on ties.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   state_t            r_state, w_state_nxt;
   owner_t            r_owner, w_sel;
   logic              w_grant, w_access_end, w_cnt_zero;
   logic              r_mem_en, r_mem_we, r_cpu_done, r_ldr_done, r_busy;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata, r_cpu_rdata, r_ldr_rdata;
`ifdef ARB_ROUND_ROBIN_EN
   owner_t            r_last_grant;
`endif

   arb_lat_counter #(
      .MEM_LAT (MEM_LAT),
      .CNT_W   (cnt_width(MEM_LAT))
   ) u_lat_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_grant),
      .i_dec  (r_state == S_ACCESS),
      .o_zero (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (cpu_req | ldr_req) w_state_nxt = S_ACCESS;
         S_ACCESS: if (w_cnt_zero)        w_state_nxt = S_RESP;
         S_RESP:                          w_state_nxt = S_IDLE;
         default:                         w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_grant      = (r_state == S_IDLE) & (cpu_req | ldr_req);
      w_access_end = (r_state == S_ACCESS) & w_cnt_zero;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie the side not served last goes first; a lone requester always wins.
      if (cpu_req & ldr_req) w_sel = (r_last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU;
      else                   w_sel = ldr_req ? OWN_LDR : OWN_CPU;
`else
      w_sel = (ldr_req & ~cpu_req) ? OWN_LDR : OWN_CPU;
`endif
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst)          r_last_grant <= OWN_LDR;
      else if (w_grant) r_last_grant <= w_sel;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner     <= OWN_CPU;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_rdata <= '0;
         r_ldr_rdata <= '0;
         r_cpu_done  <= 1'b0;
         r_ldr_done  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cpu_done <= 1'b0;
         r_ldr_done <= 1'b0;
         r_busy     <= (w_state_nxt != S_IDLE);
         if (w_grant) begin
            r_owner  <= w_sel;
            r_mem_en <= 1'b1;
            if (w_sel == OWN_LDR) begin
               r_mem_we    <= ldr_we;
               r_mem_addr  <= ldr_addr;
               r_mem_wdata <= ldr_wdata;
            end else begin
               r_mem_we    <= cpu_we;
               r_mem_addr  <= cpu_addr;
               r_mem_wdata <= cpu_wdata;
            end
         end
         // Last access cycle: capture read data and raise done for the S_RESP cycle.
         if (w_access_end) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_owner == OWN_LDR) begin
               r_ldr_done <= 1'b1;
               if (!r_mem_we) r_ldr_rdata <= mem_rdata;
            end else begin
               r_cpu_done <= 1'b1;
               if (!r_mem_we) r_cpu_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_rdata = r_cpu_rdata;
   assign ldr_rdata = r_ldr_rdata;
   assign cpu_done  = r_cpu_done;
   assign ldr_done  = r_ldr_done;
   assign busy      = r_busy;
   assign owner     = r_owner;
   assign cpu_stall = cpu_req & ~r_cpu_done;

endmodule
